// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and types for the CAN datapath message/buffer RAM.
//   RAM_DATA_WIDTH / RAM_ADDR_WIDTH / RAM_DEPTH : default geometry used by CAN buffer instances
//   ramAccess_e  : decoded external access for one clock edge
//   ramIdxWidth(): number of bits needed to index DEPTH words (minimum 1)
package ram_pkg;

  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 9;
  localparam int RAM_DEPTH      = 512;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_READ  = 2'd2
  } ramAccess_e;

  function automatic int ramIdxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// ram_clear_ctrl: post-reset clear sweep sequencer for the RAM array.
//   clk     in  : system clock
//   rstN    in  : asynchronous active-low reset; restarts the sweep from address 0
//   busy    out : high from reset until the last word has been cleared
//   clrAddr out : word address being cleared this cycle
//   clrWrEn out : write strobe for the zero write at clrAddr
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int IDX_W = ramIdxWidth(RAM_DEPTH)
) (
  input  logic             clk,
  input  logic             rstN,
  output logic             busy,
  output logic [IDX_W-1:0] clrAddr,
  output logic             clrWrEn
);

  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEPTH - 1);

  // One word per clock; busy falls on the edge that clears the last word,
  // so the sweep occupies exactly DEPTH edges after reset release.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      clrAddr <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (clrAddr == LAST_ADDR) begin
        busy <= 1'b0;
      end else begin
        clrAddr <= clrAddr + 1'b1;
      end
    end
  end

  // Gated by rstN so that clocks seen while reset is held never write the array.
  assign clrWrEn = busy && rstN;

endmodule

// File: rtl/ram.sv
// ram: single-port synchronous RAM with a shared tri-state data bus.
//   clk     in    : system clock
//   rstN    in    : asynchronous active-low reset (starts the clear sweep)
//   addr    in    : word address
//   chipSel in    : active-high select; low means no update and bus floats
//   wriEn   in    : active-high write enable; master drives data while high
//   outEn   in    : active-high output enable for reads
//   data    inout : shared data bus
//   busy    out   : high while the post-reset clear sweep runs
module ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DEPTH      = RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  chipSel,
  input  logic                  wriEn,
  input  logic                  outEn,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  busy
);

  localparam int IDX_W = ramIdxWidth(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] readReg;
  logic [IDX_W-1:0]      clrAddr;
  logic [IDX_W-1:0]      wordIdx;
  logic                  clrWrEn;
  logic                  inRange;
  ramAccess_e            access;

  ram_clear_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) uClearCtrl (
    .clk     (clk),
    .rstN    (rstN),
    .busy    (busy),
    .clrAddr (clrAddr),
    .clrWrEn (clrWrEn)
  );

  assign wordIdx = addr[IDX_W-1:0];

  // When the array fills the whole address space every address is valid;
  // otherwise the upper part of the space is unmapped.
  generate
    if (DEPTH == (1 << ADDR_WIDTH)) begin : gFullMap
      assign inRange = 1'b1;
    end else begin : gPartMap
      assign inRange = (addr < ADDR_WIDTH'(DEPTH));
    end
  endgenerate

  always_comb begin
    access = ACC_IDLE;
    if (!busy && chipSel) begin
      access = wriEn ? ACC_WRITE : ACC_READ;
    end
  end

  // Array port: the clear sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (clrWrEn) begin
      mem[clrAddr] <= '0;
    end else if (access == ACC_WRITE && inRange) begin
      mem[wordIdx] <= data;
    end
  end

  // Read register: writes load the bus value (write-through, even when the
  // address is unmapped); reads of unmapped addresses return zero.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      readReg <= '0;
    end else begin
      case (access)
        ACC_WRITE: readReg <= data;
        ACC_READ:  readReg <= inRange ? mem[wordIdx] : '0;
        default:   readReg <= readReg;
      endcase
    end
  end

  // Purely combinational bus enable; wriEn always wins over outEn.
  assign data = (!busy && chipSel && outEn && !wriEn) ? readReg : 'z;

endmodule

// File: tb/tb_ram.sv
// tb_ram: directed bench for ram with an array-level reference model.
// The bus carries pull-ups, so a released bus reads all ones.
module tb_ram;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          chipSel = 1'b1;
  logic          wriEn = 1'b0;
  logic          outEn = 1'b1;
  logic [DW-1:0] tbDrv = '0;
  logic          tbDrvEn = 1'b0;
  wire  [DW-1:0] dataBus;
  logic          busy;

  int tests = 0;
  int fails = 0;
  bit checkOn = 1'b0;

  assign dataBus = tbDrvEn ? tbDrv : 'z;

  generate
    for (genvar gi = 0; gi < DW; gi++) begin : gPull
      pullup (dataBus[gi]);
    end
  endgenerate

  ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .rstN    (rstN),
    .addr    (addr),
    .chipSel (chipSel),
    .wriEn   (wriEn),
    .outEn   (outEn),
    .data    (dataBus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] mMem [DEPTH];
  logic [DW-1:0] mRead = '0;
  int            mSweep = 0;   // words cleared since reset; DEPTH means idle

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mRead  = '0;
      mSweep = 0;
    end else begin
      if (mSweep >= DEPTH && chipSel) begin
        if (wriEn) begin
          if (int'(addr) < DEPTH) mMem[int'(addr)] = tbDrv;
          mRead = tbDrv;
        end else begin
          mRead = (int'(addr) < DEPTH) ? mMem[int'(addr)] : '0;
        end
      end
      if (mSweep < DEPTH) begin
        mMem[mSweep] = '0;
        mSweep++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      logic          expBusy;
      logic [DW-1:0] expBus;
      expBusy = (mSweep < DEPTH);
      if (!expBusy && chipSel && outEn && !wriEn) expBus = mRead;
      else if (tbDrvEn)                           expBus = tbDrv;
      else                                        expBus = '1;
      check("cyc_busy", 32'(busy), 32'(expBusy));
      check("cyc_bus", 32'(dataBus), 32'(expBus));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input int a, input logic [DW-1:0] v);
    addr = AW'(a); chipSel = 1'b1; wriEn = 1'b1; tbDrv = v; tbDrvEn = 1'b1;
    tick();
    wriEn = 1'b0; tbDrvEn = 1'b0;
    $display("[TB] write addr=%0d data=%02h", a, v);
  endtask

  task automatic doRead(input string name, input int a, input logic [DW-1:0] exp);
    addr = AW'(a); chipSel = 1'b1; wriEn = 1'b0; tbDrvEn = 1'b0; outEn = 1'b1;
    tick();
    #1;
    $display("[TB] read  addr=%0d data=%02h expect=%02h", a, dataBus, exp);
    check(name, 32'(dataBus), 32'(exp));
  endtask

  // Counts negedges with busy high; bounded so a stuck busy still ends.
  task automatic measureSweep(input string name);
    int  cnt = 0;
    bit  done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else done = 1'b1;
    end
    $display("[TB] sweep busy cycles=%0d", cnt);
    check(name, 32'(cnt), 32'd512);
    tick();
  endtask

  initial begin
    tick();
    tick();
    checkOn = 1'b1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_bus_float", 32'(dataBus), 32'hFF);

    // Release reset with chipSel/outEn held high; sweep must run 512 cycles.
    rstN = 1'b1;
    measureSweep("sweep_len");
    doRead("clr_0", 0, 8'h00);
    doRead("clr_255", 255, 8'h00);
    doRead("clr_511", 511, 8'h00);

    // Write / read-back.
    doWrite(3, 8'hA5);
    doWrite(511, 8'h5A);
    doRead("rb_3", 3, 8'hA5);
    doRead("rb_511", 511, 8'h5A);

    // Bus release (read register holds A5 from addr 3).
    doRead("rb_3_again", 3, 8'hA5);
    outEn = 1'b0; #1; check("rel_outEn", 32'(dataBus), 32'hFF);
    outEn = 1'b1; #1; check("restore_outEn", 32'(dataBus), 32'hA5);
    chipSel = 1'b0; #1; check("rel_chipSel", 32'(dataBus), 32'hFF);
    chipSel = 1'b1; #1; check("restore_chipSel", 32'(dataBus), 32'hA5);
    tick();
    wriEn = 1'b1; #1; check("rel_wriEn", 32'(dataBus), 32'hFF);
    wriEn = 1'b0; #1; check("restore_wriEn", 32'(dataBus), 32'hA5);
    $display("[TB] bus release sequence done");

    // Deselected cycle: a write attempt must change neither array nor read register.
    addr = AW'(511); chipSel = 1'b0; wriEn = 1'b1; tbDrv = 8'hEE; tbDrvEn = 1'b1;
    tick();
    tbDrvEn = 1'b0; wriEn = 1'b0; chipSel = 1'b1; #1;
    $display("[TB] deselected write addr=511 data=ee");
    check("desel_hold", 32'(dataBus), 32'hA5);
    doRead("desel_511", 511, 8'h5A);

    // Write-through with outEn high: bus shows the value as soon as wriEn drops.
    outEn = 1'b1;
    doWrite(7, 8'h3C);
    #1;
    check("wthru_7", 32'(dataBus), 32'h3C);

    // Out-of-range write is dropped but still loads the read register.
    doWrite(88, 8'h11);
    doWrite(600, 8'h77);
    #1;
    check("oor_wthru", 32'(dataBus), 32'h77);
    doRead("oor_read", 600, 8'h00);
    doRead("alias_88", 88, 8'h11);

    // Sequential sweep after filling mem[i] = i.
    for (int i = 0; i < 16; i++) doWrite(i, DW'(i));
    for (int k = 0; k < 16; k++) doRead("seq_read", k, DW'(k));

    // Reset mid-sweep with address 300 pre-filled.
    doWrite(300, 8'hFF);
    doRead("pre_300", 300, 8'hFF);
    rstN = 1'b0; #1;
    check("async_busy", 32'(busy), 32'd1);
    tick();
    rstN = 1'b1;
    repeat (100) tick();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    measureSweep("resweep_len");
    doRead("resweep_300", 300, 8'h00);
    doRead("resweep_3", 3, 8'h00);

    checkOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
